// File: rtl/mu0_mem_ctrl_if.sv
// ============================================================================
// Module      : mu0_mem_ctrl_if
// Description : Request/ready bus between the MU0 control unit and its memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mu0_mem_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12
);
    logic              memrq;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] in_data;
    logic [DATA_W-1:0] out_data;
    logic              ready;
    logic              err;
    logic              busy;

    modport master (
        output memrq, rw, addr, in_data,
        input  out_data, ready, err, busy
    );

    modport slave (
        input  memrq, rw, addr, in_data,
        output out_data, ready, err, busy
    );
endinterface

`default_nettype wire

// File: rtl/mu0_mem_ctrl.sv
// ============================================================================
// Module      : mu0_mem_ctrl
// Description : MU0 single-port synchronous memory with programmable wait
//               states, one-cycle ready pulse and out-of-range error flag.
//               Optional macro MEM_ZEROIZE_EN clears memory after reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mu0_mem_ctrl #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 12,
    parameter int DEPTH       = 32,
    parameter int WAIT_STATES = 0
) (
    input  wire logic       clk,
    input  wire logic       mem_rst_n,
    mu0_mem_ctrl_if.slave   bus
);

    localparam int               c_IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]  c_DEPTH     = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]       c_WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
`ifdef MEM_ZEROIZE_EN
        ,
        S_INIT = 2'd3
`endif
    } state_t;

`ifdef MEM_ZEROIZE_EN
    localparam state_t              c_RST_STATE = S_INIT;
    localparam logic [c_IDX_W-1:0]  c_LAST_IDX  = c_IDX_W'(DEPTH - 1);
    logic [c_IDX_W-1:0]             r_init_idx;
`else
    localparam state_t              c_RST_STATE = S_IDLE;
`endif

    state_t              r_state;
    state_t              w_next;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cnt_next;
    logic                r_rw;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_oor;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_take;
    logic                w_commit;
    logic                w_acc_rw;
    logic [ADDR_W-1:0]   w_acc_addr;
    logic [DATA_W-1:0]   w_acc_wdata;
    logic                w_in_range;
    logic [c_IDX_W-1:0]  w_idx;
    logic                w_mem_we;
    logic [c_IDX_W-1:0]  w_mem_idx;
    logic [DATA_W-1:0]   w_mem_wdata;
    logic                w_rd_en;

    // With zero wait states the access commits on the request edge itself,
    // so the live bus values are used instead of the latched copies.
    assign w_take      = (r_state == S_IDLE) && bus.memrq;
    assign w_acc_rw    = (r_state == S_IDLE) ? bus.rw      : r_rw;
    assign w_acc_addr  = (r_state == S_IDLE) ? bus.addr    : r_addr;
    assign w_acc_wdata = (r_state == S_IDLE) ? bus.in_data : r_wdata;
    assign w_in_range  = {1'b0, w_acc_addr} < c_DEPTH;
    assign w_idx       = w_acc_addr[c_IDX_W-1:0];

    always_comb begin
        w_next      = r_state;
        w_cnt_next  = r_cnt;
        w_commit    = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_idx   = w_idx;
        w_mem_wdata = w_acc_wdata;
        w_rd_en     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.memrq) begin
                    if (WAIT_STATES > 0) begin
                        w_next     = S_BUSY;
                        w_cnt_next = c_WAIT_LOAD;
                    end else begin
                        w_next   = S_RESP;
                        w_commit = 1'b1;
                    end
                end
            end
            S_BUSY: begin
                if (r_cnt == 4'd0) begin
                    w_next   = S_RESP;
                    w_commit = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
`ifdef MEM_ZEROIZE_EN
            S_INIT: begin
                w_mem_we    = 1'b1;
                w_mem_idx   = r_init_idx;
                w_mem_wdata = '0;
                if (r_init_idx == c_LAST_IDX) begin
                    w_next = S_IDLE;
                end
            end
`endif
            default: begin
                w_next = S_IDLE;
            end
        endcase
        if (w_commit && w_in_range) begin
            w_mem_we = !w_acc_rw;
            w_rd_en  = w_acc_rw;
        end
    end

    always_ff @(posedge clk) begin
        if (!mem_rst_n) begin
            r_state    <= c_RST_STATE;
            r_cnt      <= 4'd0;
            r_rw       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_out_data <= '0;
            r_oor      <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (w_take) begin
                r_rw    <= bus.rw;
                r_addr  <= bus.addr;
                r_wdata <= bus.in_data;
            end
            if (w_rd_en) begin
                r_out_data <= r_mem[w_idx];
            end
            if (w_commit) begin
                r_oor <= !w_in_range;
            end
        end
    end

`ifdef MEM_ZEROIZE_EN
    always_ff @(posedge clk) begin
        if (!mem_rst_n) begin
            r_init_idx <= '0;
        end else if (r_state == S_INIT) begin
            r_init_idx <= r_init_idx + 1'b1;
        end
    end
`endif

    // Gating on reset drops a pending write when reset aborts the access.
    always_ff @(posedge clk) begin
        if (mem_rst_n && w_mem_we) begin
            r_mem[w_mem_idx] <= w_mem_wdata;
        end
    end

    assign bus.out_data = r_out_data;
    assign bus.ready    = (r_state == S_RESP);
    assign bus.err      = (r_state == S_RESP) && r_oor;
    assign bus.busy     = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: doc/mu0_mem_ctrl.md
Name: mu0_mem_ctrl

Overview:
- Parametrised single-port synchronous memory for the MU0 datapath with a request/ready handshake and programmable wait states.
- Generalises the 32x16 memory in data width, depth and latency; adds out-of-range error reporting and a one-cycle ready pulse.
- Sits between the MU0 control unit (memrq/rw) and the address/data buses.

Parameters:
- DATA_W, 16, data word width in bits
- ADDR_W, 12, address bus width in bits
- DEPTH, 32, number of words implemented; must satisfy 1 <= DEPTH <= 2**ADDR_W
- WAIT_STATES, 0, extra cycles inserted before ready; range 0..15

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- mem_rst_n  input  1  synchronous, active-low reset
- memrq  input  1  memory request, sampled only in IDLE
- rw  input  1  1 = read, 0 = write; sampled with memrq
- addr  input  ADDR_W  word address; sampled with memrq
- in_data  input  DATA_W  write data; sampled with memrq
- out_data  output  DATA_W  registered read data
- ready  output  1  one-cycle completion pulse
- err  output  1  address out of range; valid only while ready=1
- busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset: clk and mem_rst_n form a single clock, with reset synchronous and active-low. When mem_rst_n=0 at a rising edge, the block goes to IDLE (or INIT, see optional feature) and drives out_data=0, ready=0, err=0, busy=0, wait counter=0.
- Reset mid-operation aborts the access. A write not yet committed is dropped. Memory contents are not cleared unless MEM_ZEROIZE_EN is defined.
- FSM states: IDLE, BUSY, RESP (plus INIT when the optional feature is enabled).
- IDLE: at an edge with memrq=1, latch addr, rw and in_data. Go to BUSY with counter=WAIT_STATES-1 if WAIT_STATES>0; otherwise go to RESP.
- BUSY: counter decrements each cycle. At the edge where counter=0, go to RESP.
- Commit on the edge entering RESP:
  - Write in range: mem[addr] <= in_data.
  - Read in range: out_data <= mem[addr].
  - Out of range (latched addr >= DEPTH): no memory change, out_data unchanged, err=1.
- RESP: ready=1 for exactly one cycle, then return to IDLE. memrq is ignored in RESP and BUSY.
- Latency: request edge to ready-high is WAIT_STATES+1 cycles. With memrq held high, back-to-back throughput is one access per WAIT_STATES+2 cycles.
- out_data holds the last successful read value. Writes never alter out_data; no Z or pattern values are ever driven.
- Read-after-write to the same address returns the newly written data, since the write is committed before the read request is accepted.
- err is 0 whenever ready is 0.
- Inputs changing while busy=1 have no effect.

Optional Feature:
- Macro: MEM_ZEROIZE_EN.
- Defined: after reset the block enters INIT with busy=1. An internal index writes 0 to mem[0]..mem[DEPTH-1], one word per cycle. It enters IDLE on the cycle after writing mem[DEPTH-1], so busy stays high for exactly DEPTH cycles after reset release. memrq is ignored during INIT.
- Not defined: no INIT state. The block is in IDLE immediately after reset and memory is uninitialised (X in simulation).

Test Plan:
1. Defaults, reset, write 16'hA5A5 to addr 3, then read addr 3 -> ready pulses 1 cycle after each request edge; out_data=16'hA5A5, err=0.
2. WAIT_STATES=3, read addr 5 after writing 16'h1234 -> ready high exactly 4 cycles after the request edge, busy high for 4 cycles, out_data=16'h1234.
3. Read addr 3 (16'hA5A5), then write 16'hFFFF to addr 7 -> out_data stays 16'hA5A5 through and after the write.
4. Write 16'hBEEF to addr 40 (DEPTH=32), then read addr 40 -> both accesses return ready=1, err=1; out_data unchanged; mem[8] not modified.
5. WAIT_STATES=2, write 16'h0F0F to addr 1, assert mem_rst_n=0 on the 2nd BUSY cycle, then read addr 1 -> the read returns the old value, not 16'h0F0F; ready=0, busy=0 during reset.
6. MEM_ZEROIZE_EN, DEPTH=8 -> busy=1 for 8 cycles after reset release; a request during INIT is ignored; read of addr 0..7 afterwards returns 0.
